branch_resolve_queue: RTL

In-order tracking queue that sits directly upstream of gshare_predictor's update port. Fetch allocates one entry per predicted branch, holding the PC, predicted direction and GHR snapshot. Execute resolves branches oldest-first. The block pops the head and drives the predictor's training inputs (branch_resolved, branch_taken, pc). It also flags mispredictions and supplies the corrected GHR value used for recovery.

---
 rtl/branch_resolve_queue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/branch_resolve_queue.sv
// In-order branch tracking queue feeding the gshare predictor's training port.
// Pops the oldest branch on resolve, flags mispredictions and flushes wrong-path entries.
module branch_resolve_queue #(
    parameter int GHR_WIDTH = 8,
    parameter int DEPTH     = 8,
    parameter int PC_WIDTH  = 32,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_valid,
    input  logic [PC_WIDTH-1:0]  alloc_pc,
    input  logic                 alloc_pred_taken,
    input  logic [GHR_WIDTH-1:0] alloc_ghr,
    output logic                 alloc_ready,
    input  logic                 res_valid,
    input  logic                 res_taken,
    output logic                 branch_resolved,
    output logic                 branch_taken,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 mispredict,
    output logic [GHR_WIDTH-1:0] restore_ghr,
    output logic                 res_err,
    output logic [CNT_W-1:0]     count
);

    logic [PC_WIDTH-1:0]  pc_mem_q   [DEPTH];
    logic                 pred_mem_q [DEPTH];
    logic [GHR_WIDTH-1:0] ghr_mem_q  [DEPTH];

    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 resolved_q, resolved_d;
    logic                 taken_q, taken_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic                 mis_q, mis_d;
    logic [GHR_WIDTH-1:0] rghr_q, rghr_d;
    logic                 err_q, err_d;

    logic                 do_alloc, do_pop, pop_mis, wr_en;
    logic [PC_WIDTH-1:0]  head_pc;
    logic                 head_pred;
    logic [GHR_WIDTH-1:0] head_ghr;
    logic                 ghr_msb_unused;

    assign alloc_ready    = (count_q != CNT_W'(DEPTH));
    assign do_alloc       = alloc_valid && alloc_ready;
    assign do_pop         = res_valid && (count_q != '0);
    assign head_pc        = pc_mem_q[head_q];
    assign head_pred      = pred_mem_q[head_q];
    assign head_ghr       = ghr_mem_q[head_q];
    assign pop_mis        = do_pop && (head_pred ^ res_taken);
    // The oldest GHR bit is shifted out of the restored history.
    assign ghr_msb_unused = head_ghr[GHR_WIDTH-1];
    assign wr_en          = do_alloc && !pop_mis;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        resolved_d = 1'b0;
        mis_d      = 1'b0;
        err_d      = 1'b0;
        taken_d    = taken_q;
        pc_d       = pc_q;
        rghr_d     = rghr_q;

        if (res_valid) begin
            if (do_pop) begin
                resolved_d = 1'b1;
                taken_d    = res_taken;
                pc_d       = head_pc;
                mis_d      = head_pred ^ res_taken;
                rghr_d     = {head_ghr[GHR_WIDTH-2:0], res_taken};
            end else begin
                err_d = 1'b1;
            end
        end

        if (pop_mis) begin
            // Everything younger than the mispredicted branch, including a
            // same-cycle allocation, is wrong-path: empty the queue.
            head_d  = head_q + PTR_W'(1);
            tail_d  = head_q + PTR_W'(1);
            count_d = '0;
        end else begin
            if (do_alloc) tail_d = tail_q + PTR_W'(1);
            if (do_pop)   head_d = head_q + PTR_W'(1);
            if (do_alloc && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_alloc && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            resolved_q <= 1'b0;
            taken_q    <= 1'b0;
            pc_q       <= '0;
            mis_q      <= 1'b0;
            rghr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            resolved_q <= resolved_d;
            taken_q    <= taken_d;
            pc_q       <= pc_d;
            mis_q      <= mis_d;
            rghr_q     <= rghr_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem_q[tail_q]   <= alloc_pc;
            pred_mem_q[tail_q] <= alloc_pred_taken;
            ghr_mem_q[tail_q]  <= alloc_ghr;
        end
    end

    assign branch_resolved = resolved_q;
    assign branch_taken    = taken_q;
    assign pc              = pc_q;
    assign mispredict      = mis_q;
    assign restore_ghr     = rghr_q;
    assign res_err         = err_q;
    assign count           = count_q;

endmodule
